// File: rtl/mat_mult.sv
// Element-wise (Hadamard) product of two signed 32-bit matrices using one
// shared multiplier that walks the elements in row-major order, one per clock.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for enable_mult; capture edge snapshots operands
//   COMPUTE | writing mat_out[row][col] each cycle, abort if enable drops
//   DONE    | result presented, mult_done=1 until enable_mult falls
module mat_mult #(
   parameter int N_ROWS    = 3,
   parameter int N_COLUMNS = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable_mult,
   input  int   mat1    [0:N_ROWS-1][0:N_COLUMNS-1],
   input  int   mat2    [0:N_ROWS-1][0:N_COLUMNS-1],
   output int   mat_out [0:N_ROWS-1][0:N_COLUMNS-1],
   output logic mult_done
);

   localparam int RW = (N_ROWS    > 1) ? $clog2(N_ROWS)    : 1;
   localparam int CW = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [RW-1:0]  row;
   logic [CW-1:0]  col;
   int             op_a [0:N_ROWS-1][0:N_COLUMNS-1];
   int             op_b [0:N_ROWS-1][0:N_COLUMNS-1];
   int             product;
   logic           last_elem;
   logic           capture;
   logic           write_en;

   assign last_elem = (row == RW'(N_ROWS - 1)) && (col == CW'(N_COLUMNS - 1));

   // int * int keeps only the low 32 bits, giving two's-complement wrap
   assign product = op_a[row][col] * op_b[row][col];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (enable_mult) begin
               state_nxt = COMPUTE;
            end
         end
         COMPUTE: begin
            if (!enable_mult) begin
               state_nxt = IDLE;
            end else if (last_elem) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (!enable_mult) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mult_done = 1'b0;
      capture   = 1'b0;
      write_en  = 1'b0;
      case (state)
         IDLE:    capture   = enable_mult;
         COMPUTE: write_en  = enable_mult;
         DONE:    mult_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row <= '0;
         col <= '0;
         for (int i = 0; i < N_ROWS; i++) begin
            for (int j = 0; j < N_COLUMNS; j++) begin
               op_a[i][j]    <= 0;
               op_b[i][j]    <= 0;
               mat_out[i][j] <= 0;
            end
         end
      end else if (capture) begin
         row <= '0;
         col <= '0;
         for (int i = 0; i < N_ROWS; i++) begin
            for (int j = 0; j < N_COLUMNS; j++) begin
               op_a[i][j]    <= mat1[i][j];
               op_b[i][j]    <= mat2[i][j];
               mat_out[i][j] <= 0;
            end
         end
      end else if (write_en) begin
         mat_out[row][col] <= product;
         if (col == CW'(N_COLUMNS - 1)) begin
            col <= '0;
            row <= last_elem ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mat_mult.sv
// Directed bench for mat_mult (3x2): stimulus pushes expected results into a
// scoreboard, a monitor pops and checks each rising mult_done.
module tb_mat_mult;

   typedef int mat_t [0:2][0:1];
   typedef struct {
      mat_t m;
      int   e0;
   } exp_t;

   logic clk;
   logic reset;
   logic enable_mult;
   mat_t mat1;
   mat_t mat2;
   mat_t mat_out;
   logic mult_done;

   int   checks;
   int   errors;
   int   cyc;
   exp_t sb [$];
   logic prev_done;

   mat_t d1, d2, dexp, s1, s2, sexp, nines, r1, r2, rexp, zero, abort_exp;

   mat_mult #(.N_ROWS(3), .N_COLUMNS(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable_mult (enable_mult),
      .mat1        (mat1),
      .mat2        (mat2),
      .mat_out     (mat_out),
      .mult_done   (mult_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   function automatic bit mat_eq(input mat_t a, input mat_t b);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 2; j++)
            if (a[i][j] != b[i][j]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check_mat(input string name, input mat_t exp);
      checks++;
      if (!mat_eq(mat_out, exp)) begin
         errors++;
         $display("FAIL %s got %p expected %p", name, mat_out, exp);
      end
   endtask

   task automatic check_done(input string name, input logic exp);
      checks++;
      if (mult_done !== exp) begin
         errors++;
         $display("FAIL %s mult_done got %b expected %b", name, mult_done, exp);
      end
   endtask

   // capture happens at the next rising edge after this negedge
   task automatic push_exp(input mat_t m);
      exp_t e;
      e.m  = m;
      e.e0 = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!mult_done && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!mult_done) begin
         errors++;
         $display("FAIL %s timeout waiting for mult_done got 0 expected 1", name);
      end
   endtask

   // latency counts rising edges from the capture edge through the edge that raised mult_done
   always @(negedge clk) begin
      if (mult_done && !prev_done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done got result %p expected none", mat_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (!mat_eq(mat_out, e.m)) begin
               errors++;
               $display("FAIL result got %p expected %p", mat_out, e.m);
            end
            checks++;
            if (cyc - e.e0 + 1 != 7) begin
               errors++;
               $display("FAIL latency got %0d expected 7", cyc - e.e0 + 1);
            end
         end
      end
      prev_done = mult_done;
   end

   initial begin
      checks      = 0;
      errors      = 0;
      prev_done   = 1'b0;
      d1          = '{'{1, 2}, '{3, 4}, '{5, 6}};
      d2          = '{'{1, 2}, '{3, 4}, '{0, 0}};
      dexp        = '{'{1, 4}, '{9, 16}, '{0, 0}};
      s1          = '{'{-3, 7}, '{32'h7FFFFFFF, -1}, '{2, int'(32'h80000000)}};
      s2          = '{'{4, -5}, '{2, -1}, '{-8, -1}};
      sexp        = '{'{-12, -35}, '{-2, 1}, '{-16, int'(32'h80000000)}};
      nines       = '{'{9, 9}, '{9, 9}, '{9, 9}};
      r1          = '{'{10, -20}, '{30, 0}, '{1, 1}};
      r2          = '{'{2, 3}, '{-1, 5}, '{-7, 100}};
      rexp        = '{'{20, -60}, '{-30, 0}, '{-7, 100}};
      zero        = '{'{0, 0}, '{0, 0}, '{0, 0}};
      abort_exp   = '{'{1, 4}, '{9, 0}, '{0, 0}};
      reset       = 1'b1;
      enable_mult = 1'b0;
      mat1        = zero;
      mat2        = zero;

      @(negedge clk);
      check_mat("reset_mat_out", zero);
      check_done("reset_done", 1'b0);

      // default 3x2
      reset       = 1'b0;
      mat1        = d1;
      mat2        = d2;
      enable_mult = 1'b1;
      push_exp(dexp);
      wait_done("default");

      // hold with enable high: input changes must not restart
      for (int k = 0; k < 3; k++) begin
         mat1 = s1;
         mat2 = s2;
         @(negedge clk);
         check_done("hold_done", 1'b1);
         check_mat("hold_mat_out", dexp);
      end

      // drop for one cycle, restart with signed/wrap vectors
      enable_mult = 1'b0;
      @(negedge clk);
      check_done("drop_done", 1'b0);
      check_mat("drop_kept", dexp);
      enable_mult = 1'b1;
      push_exp(sexp);
      @(negedge clk);
      check_mat("capture_clear", zero);
      wait_done("signed");

      // operand snapshot
      enable_mult = 1'b0;
      @(negedge clk);
      mat1        = d1;
      mat2        = d2;
      enable_mult = 1'b1;
      push_exp(dexp);
      @(negedge clk);
      mat1 = nines;
      wait_done("snapshot");

      // abort after three COMPUTE writes
      enable_mult = 1'b0;
      @(negedge clk);
      mat1        = d1;
      mat2        = d2;
      enable_mult = 1'b1;
      repeat (4) @(negedge clk);
      enable_mult = 1'b0;
      @(negedge clk);
      check_mat("abort_mat_out", abort_exp);
      check_done("abort_done", 1'b0);
      @(negedge clk);
      check_done("abort_idle_done", 1'b0);
      check_mat("abort_retained", abort_exp);
      enable_mult = 1'b1;
      push_exp(dexp);
      wait_done("after_abort");

      // asynchronous reset mid-COMPUTE
      enable_mult = 1'b0;
      @(negedge clk);
      mat1        = r1;
      mat2        = r2;
      enable_mult = 1'b1;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_mat("async_reset_mat_out", zero);
      check_done("async_reset_done", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      push_exp(rexp);
      wait_done("after_reset");

      enable_mult = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
